demux_scheduler: RTL

DEMUX_SCHEDULER -- requirements
Module: demux_scheduler

---
 rtl/demux_sched_pkg.sv | 6 +
 rtl/demux_sel_ctr.sv | 43 ++++
 rtl/demux_scheduler.sv | 62 ++++++
 3 files changed

// File: rtl/demux_sched_pkg.sv
// demux_sched_pkg: shared FSM encoding and select width for the demux scheduler
package demux_sched_pkg;
    localparam int N_OUT_DEF = 4;
    localparam int SEL_W = $clog2(N_OUT_DEF);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
endpackage

// File: rtl/demux_sel_ctr.sv
// demux_sel_ctr: per-channel beat counting and select-pointer advance at burst boundaries
module demux_sel_ctr
    import demux_sched_pkg::*;
#(
    parameter int N_OUT = N_OUT_DEF,
    parameter int BURST_W = 4
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_deliver,
    input  logic                       i_idle,
    input  logic                       i_cfg_mode,
    input  logic [$clog2(N_OUT)-1:0]   i_cfg_fixed_sel,
    input  logic [BURST_W-1:0]         i_cfg_burst,
    output logic [$clog2(N_OUT)-1:0]   o_sel
);
    localparam int SW = $clog2(N_OUT);
    localparam logic [SW-1:0] S1 = SW'(1);
    localparam logic [BURST_W-1:0] B1 = BURST_W'(1);
    localparam logic [BURST_W:0] ONE = (BURST_W+1)'(1);
    logic [BURST_W-1:0] r_beat, r_burst;
    logic [BURST_W:0]   w_len;
    logic               w_last, w_load;
    logic [SW-1:0]      w_sel_next;
    // a burst length of zero is treated as one item per channel
    assign w_len = (r_burst == '0) ? ONE : {1'b0, r_burst};
    assign w_last = i_deliver && (({1'b0, r_beat} + ONE) == w_len);
    // burst length is only re-sampled between bursts so mid-burst edits wait
    assign w_load = w_last || (i_idle && r_beat == '0);
    assign w_sel_next = i_cfg_mode ? i_cfg_fixed_sel : o_sel + S1;
    // beat counter, latched burst length and select pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat  <= '0;
            r_burst <= '0;
            o_sel   <= '0;
        end else begin
            if (i_deliver) r_beat <= w_last ? '0 : r_beat + B1;
            if (w_last) o_sel <= w_sel_next;
            if (w_load) r_burst <= i_cfg_burst;
        end
    end
endmodule

// File: rtl/demux_scheduler.sv
// demux_scheduler: single-entry holding register steering items to one of N_OUT channels
module demux_scheduler
    import demux_sched_pkg::*;
#(
    parameter int N_OUT = N_OUT_DEF,
    parameter int DATA_W = 8,
    parameter int BURST_W = 4
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic [N_OUT-1:0]           out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic [N_OUT-1:0]           out_ready,
    output logic [$clog2(N_OUT)-1:0]   sel,
    input  logic                       cfg_mode,
    input  logic [$clog2(N_OUT)-1:0]   cfg_fixed_sel,
    input  logic [BURST_W-1:0]         cfg_burst,
    output logic [15:0]                deliv_cnt
);
    localparam logic [N_OUT-1:0] OH1 = N_OUT'(1);
    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_data;
    logic [15:0]       r_cnt;
    logic              w_full, w_accept, w_deliver;
    assign w_full = r_state == FULL;
    assign w_deliver = w_full && out_ready[sel];
    // ready passes straight through from the selected channel so a full slot can refill each cycle
    assign in_ready = !w_full || out_ready[sel];
    assign w_accept = in_valid && in_ready;
    assign out_valid = w_full ? OH1 << sel : '0;
    assign out_data = r_data;
    assign deliv_cnt = r_cnt;
    // next state: accept always leaves us holding an item, a bare deliver empties the slot
    always_comb begin
        w_next = w_accept ? FULL : (w_deliver ? EMPTY : r_state);
    end
    // state, holding register and delivered-item counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_data <= in_data;
            if (w_deliver) r_cnt <= r_cnt + 16'd1;
        end
    end
    demux_sel_ctr #(.N_OUT(N_OUT), .BURST_W(BURST_W)) u_sel_ctr (
        .clk             (clk),
        .reset           (reset),
        .i_deliver       (w_deliver),
        .i_idle          (!w_full),
        .i_cfg_mode      (cfg_mode),
        .i_cfg_fixed_sel (cfg_fixed_sel),
        .i_cfg_burst     (cfg_burst),
        .o_sel           (sel)
    );
endmodule
